// File: rtl/quad_dec_pkg.sv
// Shared constants for the quadrature decoder: FSM encoding, phase codes, direction
// values and the up-sequence successor function.
package quad_dec_pkg;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  // Phases are {A, B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up sequence 00->10->11->01->00 (A leads B)
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nx;
    case (ph)
      PH_00:   nx = PH_10;
      PH_10:   nx = PH_11;
      PH_11:   nx = PH_01;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// One encoder channel: SYNC_STAGES-deep synchronizer, plus a FILT_CYCLES stability
// filter when QUAD_GLITCH_FILTER_EN is defined.
module quad_sync
  import quad_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!clr_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int CW = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Output follows only after FILT_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(FILT_CYCLES - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with up/down position counter and synchronous load.
// Optional glitch filter on both channels: define QUAD_GLITCH_FILTER_EN.
module quad_decoder
  import quad_dec_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err
);

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int INIT_LAST = SYNC_STAGES + FILT_CYCLES;
`else
  localparam int INIT_LAST = SYNC_STAGES;
`endif
  localparam int IW = $clog2(INIT_LAST + 1);

  logic a_s, b_s;
  logic [1:0] ab_s;

  quad_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sync_a (
    .clk(clk), .clr_n(clr_n), .din(ch_a), .dout(a_s)
  );
  quad_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sync_b (
    .clk(clk), .clr_n(clr_n), .din(ch_b), .dout(b_s)
  );

  assign ab_s = {a_s, b_s};

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    init_q, init_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    prev_d  = prev_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    if (state_q == ST_INIT) begin
      // Sync chain (and filter) only hold pin data once INIT_LAST edges have passed
      if (init_q == IW'(INIT_LAST)) begin
        prev_d  = ab_s;
        state_d = ST_TRACK;
      end else begin
        init_d = init_q + IW'(1);
      end
    end else begin
      prev_d = ab_s;
      if (ab_s != prev_q) begin
        if ((ab_s ^ prev_q) == 2'b11) begin
          err_d = 1'b1;
        end else begin
          step_d = 1'b1;
          dir_d  = (ab_s == next_up(prev_q)) ? DIR_UP : DIR_DN;
        end
      end
    end

    count_d = count_q;
    if (ld)
      count_d = d_in;
    else if (step_d)
      count_d = (dir_d == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      prev_q  <= PH_00;
      count_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= DIR_DN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, SYNC_STAGES=2); filter steps run only
// when QUAD_GLITCH_FILTER_EN is defined.
module tb_quad_decoder;

  localparam int S = 2;
  localparam int F = 3;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT = S + F + 1;
`else
  localparam int LAT = S + 1;
`endif

  logic       clk = 1'b0;
  logic       clr_n, ch_a, ch_b, ld;
  logic [7:0] d_in, count;
  logic       step, dir, err;

  int ncmp = 0;
  int nerr = 0;

  quad_decoder #(.WIDTH(8), .SYNC_STAGES(S), .FILT_CYCLES(F)) dut (
    .clk(clk), .clr_n(clr_n), .ch_a(ch_a), .ch_b(ch_b), .ld(ld),
    .d_in(d_in), .count(count), .step(step), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pins(input logic [1:0] ab);
    ch_a = ab[1];
    ch_b = ab[0];
  endtask

  // Apply one legal edge and check the full latency window
  task automatic edge_chk(input string tag, input logic [1:0] ab, input logic d, input logic [7:0] c);
    pins(ab);
    tick(LAT - 1);
    chk({tag, "_early"}, {31'd0, step}, 32'd0);
    tick(1);
    chk({tag, "_step"}, {31'd0, step}, 32'd1);
    chk({tag, "_dir"}, {31'd0, dir}, {31'd0, d});
    chk({tag, "_cnt"}, {24'd0, count}, {24'd0, c});
    tick(1);
    chk({tag, "_pulse"}, {31'd0, step}, 32'd0);
  endtask

  initial begin
    int any_step, any_err;

    // 1: reset with pins at 11, INIT must absorb it
    clr_n = 1'b0; ld = 1'b0; d_in = 8'h00; pins(2'b11);
    tick(2);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    clr_n = 1'b1;
    any_step = 0; any_err = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (step) any_step++;
      if (err) any_err++;
    end
    chk("init_no_step", any_step, 0);
    chk("init_no_err", any_err, 0);
    chk("init_count", {24'd0, count}, 32'd0);

    // Re-reset with pins at 00 for the up sequence
    clr_n = 1'b0; pins(2'b00);
    tick(2);
    clr_n = 1'b1;
    tick(12);

    // 2: up sequence
    edge_chk("up1", 2'b10, 1'b1, 8'h01);
    edge_chk("up2", 2'b11, 1'b1, 8'h02);
    edge_chk("up3", 2'b01, 1'b1, 8'h03);
    edge_chk("up4", 2'b00, 1'b1, 8'h04);

    // 3: underflow then overflow wrap
    ld = 1'b1; d_in = 8'h00; tick(1); ld = 1'b0;
    chk("ld0", {24'd0, count}, 32'd0);
    edge_chk("dn_wrap", 2'b01, 1'b0, 8'hFF);
    ld = 1'b1; d_in = 8'hFF; tick(1); ld = 1'b0;
    chk("ldFF", {24'd0, count}, 32'hFF);
    edge_chk("up_wrap", 2'b00, 1'b1, 8'h00);

    // 4: illegal 00->11, then a legal down edge 11->10
    pins(2'b11);
    tick(LAT - 1);
    chk("err_early", {31'd0, err}, 32'd0);
    tick(1);
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_nostep", {31'd0, step}, 32'd0);
    chk("err_count", {24'd0, count}, 32'h00);
    chk("err_dir", {31'd0, dir}, 32'd1);
    tick(1);
    chk("err_once", {31'd0, err}, 32'd0);
    edge_chk("after_err", 2'b10, 1'b0, 8'hFF);

    // 5: load wins over a simultaneous step, step still pulses
    pins(2'b11);
    tick(LAT - 1);
    ld = 1'b1; d_in = 8'h5A;
    tick(1);
    ld = 1'b0;
    chk("ldstep_step", {31'd0, step}, 32'd1);
    chk("ldstep_dir", {31'd0, dir}, 32'd1);
    chk("ldstep_cnt", {24'd0, count}, 32'h5A);
    tick(2);
    chk("ldstep_hold", {24'd0, count}, 32'h5A);

`ifdef QUAD_GLITCH_FILTER_EN
    // 6: 2-cycle glitch on A is discarded; a held edge counts once (from 11)
    ch_a = 1'b0; tick(2); ch_a = 1'b1;
    any_step = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (step) any_step++;
    end
    chk("glitch_nostep", any_step, 0);
    chk("glitch_cnt", {24'd0, count}, 32'h5A);
    edge_chk("filt_edge", 2'b01, 1'b1, 8'h5B);
    pins(2'b11);
    tick(LAT + 2);
`endif

    // 7: reset one cycle after a pin edge kills the pending step
    pins(2'b01);
    tick(1);
    clr_n = 1'b0;
    tick(1);
    chk("rst_mid_step", {31'd0, step}, 32'd0);
    chk("rst_mid_cnt", {24'd0, count}, 32'd0);
    clr_n = 1'b1;
    any_step = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (step) any_step++;
    end
    chk("rst_mid_nostep", any_step, 0);
    chk("rst_mid_cnt_after", {24'd0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
